// File: rtl/sr_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sr_cmd_seq
//  Purpose  : Command sequencer producing the S/R drive for a downstream SR
//             flip-flop. Commands (hold/reset/set/toggle) enter through a
//             valid/ready FIFO and each is played out for HOLD+1 cycles,
//             followed by a one-cycle S=R=0 guard gap.
//  Options  : SR_CMD_TOGGLE_EN - when defined, CMD=11 drives the direction
//             opposite to Q_FB; when undefined, CMD=11 behaves as hold and
//             raises the sticky ERR flag.
//  Revision : 1.0 - initial release
// ============================================================================
module sr_cmd_seq #(
    parameter int DEPTH  = 4,
    parameter int HOLD_W = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD,
    input  logic [HOLD_W-1:0] HOLD,
    input  logic              Q_FB,
    output logic              S,
    output logic              R,
    output logic              BUSY,
    output logic              ERR
);

    localparam int              c_AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_CW        = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRIVE = 2'd1;
    localparam logic [1:0] c_GAP   = 2'd2;

    localparam logic [1:0] c_CMD_RESET  = 2'b01;
    localparam logic [1:0] c_CMD_SET    = 2'b10;
    localparam logic [1:0] c_CMD_TOGGLE = 2'b11;

    // FIFO storage: each entry is {CMD, HOLD}
    logic [HOLD_W+1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_s;
    logic              r_r;
    logic              w_s_nxt;
    logic              w_r_nxt;
    logic [HOLD_W-1:0] r_hcnt;
    logic [HOLD_W-1:0] w_hcnt_nxt;
    logic              r_err;
    logic              w_err_nxt;

    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [HOLD_W+1:0] w_head;
    logic [1:0]        w_head_cmd;
    logic [HOLD_W-1:0] w_head_hold;

    // Ready depends only on the registered count, so a same-cycle pop never
    // opens the door for an extra push.
    assign CMD_READY   = (r_count < c_DEPTH_CNT);
    assign w_push      = CMD_VALID & CMD_READY;
    assign w_empty     = (r_count == '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_cmd  = w_head[HOLD_W+1:HOLD_W];
    assign w_head_hold = w_head[HOLD_W-1:0];

    assign S    = r_s;
    assign R    = r_r;
    assign ERR  = r_err;
    assign BUSY = (r_state != c_IDLE) | ~w_empty;

`ifndef SR_CMD_TOGGLE_EN
    // Feedback is only meaningful for toggle commands, which are disabled here.
    logic w_qfb_unused;
    assign w_qfb_unused = Q_FB;
`endif

    // Next-state, drive decode and pop request
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_r_nxt     = r_r;
        w_hcnt_nxt  = r_hcnt;
        w_err_nxt   = r_err;
        w_pop       = 1'b0;
        case (r_state)
            c_IDLE, c_GAP: begin
                w_s_nxt = 1'b0;
                w_r_nxt = 1'b0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_hcnt_nxt  = w_head_hold;
                    w_state_nxt = c_DRIVE;
                    case (w_head_cmd)
                        c_CMD_RESET: w_r_nxt = 1'b1;
                        c_CMD_SET:   w_s_nxt = 1'b1;
                        c_CMD_TOGGLE: begin
`ifdef SR_CMD_TOGGLE_EN
                            // Drive away from the current flop state; Q_FB is
                            // only looked at here, at the pop edge.
                            w_s_nxt = ~Q_FB;
                            w_r_nxt = Q_FB;
`else
                            w_err_nxt = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_DRIVE: begin
                if (r_hcnt != '0) begin
                    w_hcnt_nxt = r_hcnt - 1'b1;
                end else begin
                    w_s_nxt     = 1'b0;
                    w_r_nxt     = 1'b0;
                    w_state_nxt = c_GAP;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_s_nxt     = 1'b0;
                w_r_nxt     = 1'b0;
            end
        endcase
    end

    // FSM, drive outputs, hold counter and sticky error register
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= c_IDLE;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_hcnt  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_r     <= w_r_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // FIFO storage write; contents need no reset since the count is flushed
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= {CMD, HOLD};
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr_cmd_seq
//  Purpose  : Self-checking bench for sr_cmd_seq. A timeline model (command
//             queue plus drive windows) predicts every output each cycle;
//             directed tests add hand-computed literal expectations.
//  Options  : SR_CMD_TOGGLE_EN selects the toggle expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sr_cmd_seq;

    localparam int DEPTH  = 4;
    localparam int HOLD_W = 4;

    logic              CLK = 1'b0;
    logic              RSTn;
    logic              CMD_VALID;
    logic              CMD_READY;
    logic [1:0]        CMD;
    logic [HOLD_W-1:0] HOLD;
    logic              Q_FB;
    logic              S;
    logic              R;
    logic              BUSY;
    logic              ERR;

    sr_cmd_seq #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD       (CMD),
        .HOLD      (HOLD),
        .Q_FB      (Q_FB),
        .S         (S),
        .R         (R),
        .BUSY      (BUSY),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Timeline model: a command popped at edge e drives its value after
    // edges e..e+HOLD, the next pop may happen no earlier than edge
    // e+HOLD+2, and the block is busy until that edge.
    // ------------------------------------------------------------------
    int q_cmd[$];
    int q_hold[$];
    int cur = 0;
    int next_pop = 0;
    int drv_start = 0;
    int drv_end = -1;
    int sz0;
    int pc;
    int ph;
    bit drv_s = 1'b0;
    bit drv_r = 1'b0;
    bit m_err = 1'b0;
    bit m_valid = 1'b0;
    bit in_win;

    // Compare outputs after the last edge, then predict the coming edge
    initial begin
        forever begin
            @(negedge CLK);
            if (m_valid) begin
                in_win = (cur >= drv_start) && (cur <= drv_end);
                chk("model_S", S, in_win & drv_s);
                chk("model_R", R, in_win & drv_r);
                chk("model_BUSY", BUSY, (q_cmd.size() != 0) || (cur < next_pop));
                chk("model_READY", CMD_READY, q_cmd.size() < DEPTH);
                chk("model_ERR", ERR, m_err);
                chk("s_and_r", S & R, 0);
            end
            cur++;
            if (!RSTn) begin
                q_cmd.delete();
                q_hold.delete();
                next_pop = cur;
                drv_end  = -1;
                m_err    = 1'b0;
                m_valid  = 1'b1;
            end else if (m_valid) begin
                sz0 = q_cmd.size();
                if (sz0 != 0 && cur >= next_pop) begin
                    pc = q_cmd.pop_front();
                    ph = q_hold.pop_front();
                    drv_start = cur;
                    drv_end   = cur + ph;
                    next_pop  = cur + ph + 2;
                    drv_s = (pc == 2);
                    drv_r = (pc == 1);
                    if (pc == 3) begin
`ifdef SR_CMD_TOGGLE_EN
                        drv_s = !Q_FB;
                        drv_r = Q_FB;
`else
                        m_err = 1'b1;
`endif
                    end
                end
                if (CMD_VALID && sz0 < DEPTH) begin
                    q_cmd.push_back(int'(CMD));
                    q_hold.push_back(int'(HOLD));
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one command and hold it until accepted; returns stall cycles
    task automatic push(input logic [1:0] c, input logic [HOLD_W-1:0] h, output int stall);
        int n = 0;
        CMD_VALID = 1'b1;
        CMD       = c;
        HOLD      = h;
        while (!CMD_READY && n < 200) begin
            tick();
            n++;
        end
        chk("push_timeout", n < 200, 1);
        tick();
        CMD_VALID = 1'b0;
        stall = n;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 500) begin
            tick();
            n++;
        end
        chk("idle_timeout", BUSY, 0);
        tick();
    endtask

    logic [1:0] fill_cmd [5] = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01};
    logic [1:0] alt_cmd  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    int st;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus with literal expectations
    initial begin
        RSTn = 1'b0; CMD_VALID = 1'b0; CMD = 2'b00; HOLD = '0; Q_FB = 1'b0;
        repeat (3) tick();
        chk("rst_S", S, 0);
        chk("rst_R", R, 0);
        chk("rst_READY", CMD_READY, 1);
        chk("rst_BUSY", BUSY, 0);
        chk("rst_ERR", ERR, 0);
        RSTn = 1'b1;
        tick();

        // Single set, HOLD=2: S high for three cycles after the push edge
        CMD_VALID = 1'b1; CMD = 2'b10; HOLD = 4'd2;
        tick();
        CMD_VALID = 1'b0;
        chk("t1_S_push", S, 0);
        chk("t1_BUSY_push", BUSY, 1);
        tick(); chk("t1_S_1", S, 1);
        tick(); chk("t1_S_2", S, 1);
        tick(); chk("t1_S_3", S, 1); chk("t1_R_3", R, 0);
        tick(); chk("t1_S_gap", S, 0); chk("t1_BUSY_gap", BUSY, 1);
        tick(); chk("t1_BUSY_idle", BUSY, 0);
        tick();

        // Fill to full, then a sixth command stalls until the second pop
        for (int i = 0; i < 5; i++) push(fill_cmd[i], 4'd7, st);
        chk("t2_ready_full", CMD_READY, 0);
        push(2'b10, 4'd7, st);
        chk("t2_stall_cycles", st, 6);
        wait_idle();

        // Reset/set alternation with 1-cycle pulses
        for (int i = 0; i < 4; i++) push(alt_cmd[i], 4'd0, st);
        chk("t3_S_pulse2", S, 1); chk("t3_R_pulse2", R, 0);
        tick(); chk("t3_S_gap", S, 0); chk("t3_R_gap", R, 0);
        tick(); chk("t3_R_pulse3", R, 1); chk("t3_S_pulse3", S, 0);
        wait_idle();

        // Toggle with Q_FB=1; Q_FB flips during the drive and must be ignored
        Q_FB = 1'b1;
        push(2'b11, 4'd3, st);
        tick();
        Q_FB = 1'b0;
`ifdef SR_CMD_TOGGLE_EN
        chk("t4a_R", R, 1); chk("t4a_S", S, 0); chk("t4a_ERR", ERR, 0);
`else
        chk("t4a_R", R, 0); chk("t4a_S", S, 0); chk("t4a_ERR", ERR, 1);
`endif
        tick();
`ifdef SR_CMD_TOGGLE_EN
        chk("t4a_R_2", R, 1);
`else
        chk("t4a_R_2", R, 0);
`endif
        wait_idle();

        // Toggle with Q_FB=0
        push(2'b11, 4'd3, st);
        tick();
        Q_FB = 1'b1;
`ifdef SR_CMD_TOGGLE_EN
        chk("t4b_S", S, 1); chk("t4b_R", R, 0);
`else
        chk("t4b_S", S, 0); chk("t4b_R", R, 0);
`endif
        wait_idle();
`ifdef SR_CMD_TOGGLE_EN
        chk("t4_ERR_end", ERR, 0);
`else
        chk("t4_ERR_end", ERR, 1);
`endif

        // Maximum hold length
        push(2'b01, 4'd15, st);
        wait_idle();

        // Mid-drive reset with three commands queued
        push(2'b10, 4'd5, st);
        push(2'b01, 4'd5, st);
        push(2'b10, 4'd5, st);
        push(2'b01, 4'd5, st);
        chk("t6_S_driving", S, 1);
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        chk("t6_S", S, 0);
        chk("t6_R", R, 0);
        chk("t6_BUSY", BUSY, 0);
        chk("t6_READY", CMD_READY, 1);
        chk("t6_ERR", ERR, 0);
        repeat (20) tick();
        chk("t6_BUSY_after", BUSY, 0);
        chk("t6_S_after", S, 0);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sr_cmd_seq.md
# sr_cmd_seq

Command sequencer that sits directly upstream of the `sr` flip-flop and produces its S/R drive. It accepts set/reset/hold/toggle commands through a valid/ready handshake and buffers them in a small FIFO. Each command is played out on `S`/`R` for a programmable number of cycles, and a mandatory one-cycle guard gap separates consecutive commands. `S` and `R` are never asserted together. The flip-flop's `Q` is fed back so toggle commands pick the correct drive direction.

## Interface
Parameters:
- `DEPTH`, default 4: command FIFO entries; power of two, range 2–16.
- `HOLD_W`, default 4: width of the per-command hold count.

Ports:
- `CLK`, input, 1: clock; all state updates on the rising edge.
- `RSTn`, input, 1: reset; synchronous, active-low.
- `CMD_VALID`, input, 1: a command is presented.
- `CMD_READY`, output, 1: the FIFO can accept a command.
- `CMD`, input, 2: command code.
  - 00: hold, S=R=0.
  - 01: reset, R=1.
  - 10: set, S=1.
  - 11: toggle.
- `HOLD`, input, `HOLD_W`: drive length minus one, in cycles.
- `Q_FB`, input, 1: `Q` from the downstream SR flip-flop.
- `S`, output, 1: set drive; registered.
- `R`, output, 1: reset drive; registered.
- `BUSY`, output, 1: high when the FSM is not in IDLE or the FIFO is non-empty.
- `ERR`, output, 1: sticky; an unsupported command was executed.

## Operation
- **Push**
  - A command is pushed when `CMD_VALID` and `CMD_READY` are both high at a rising edge.
  - `CMD` and `HOLD` are stored together as one entry.
  - `CMD_READY = (count < DEPTH)`, derived from the registered count only.
  - A pop in the same cycle never raises `CMD_READY`.
- **FSM states**
  - IDLE
    - FIFO non-empty: pop the head entry, load `S`/`R`, set the counter to the entry's `HOLD`, go to DRIVE.
    - FIFO empty: `S`=`R`=0.
  - DRIVE
    - Hold `S`/`R` at their loaded values.
    - Counter ≠ 0: decrement it.
    - Counter = 0: clear `S`/`R` and go to GAP.
  - GAP
    - `S`=`R`=0 for exactly one cycle.
    - FIFO non-empty: pop and load as in IDLE, go to DRIVE.
    - FIFO empty: go to IDLE.
- **Drive decode at pop**
  - 00: `S`=0, `R`=0.
  - 01: `S`=0, `R`=1.
  - 10: `S`=1, `R`=0.
  - 11: see Configuration.
- **Invariant:** `S & R` is never 1 in any cycle.
- **Simultaneous push and pop** on a non-full FIFO: count is unchanged and entry order is preserved.
- **FIFO pointers** wrap modulo `DEPTH`.

## Timing
- **Reset values:** `S`=0, `R`=0, `CMD_READY`=1, `BUSY`=0, `ERR`=0. The FSM enters IDLE, the FIFO is flushed (count 0) and the counter is 0.
- **Reset mid-operation:** an in-flight drive is cut at the reset edge and all queued commands are discarded. `RSTn` has priority over push.
- **Latency:** a command pushed at edge k, with the FSM in IDLE, drives `S`/`R` from edge k+1.
- **Drive length:** `S`/`R` are held for `HOLD`+1 cycles. `HOLD`=0 gives a 1-cycle pulse; `HOLD`=2^`HOLD_W`−1 gives the maximum.
- **Back-to-back commands:** the period is `HOLD`+2 cycles (drive plus GAP).
- **Toggle sampling:** `Q_FB` is sampled at the pop edge only. Changes during DRIVE are ignored.

## Configuration
- **Macro:** `SR_CMD_TOGGLE_EN`.
- **Defined:**
  - `CMD`=11 drives `R`=1 if `Q_FB`=1, or `S`=1 if `Q_FB`=0, for `HOLD`+1 cycles.
  - `ERR` stays 0.
- **Undefined:**
  - `CMD`=11 executes as hold: `S`=`R`=0 for `HOLD`+1 cycles, followed by the normal GAP.
  - `ERR` is set at the pop edge and stays 1 until reset.
  - `Q_FB` is unused.

## Test plan
- **Reset and single set:**
  - Stimulus: release `RSTn` and push `CMD`=10, `HOLD`=2 at edge 5.
  - Required: `S`=1 during cycles 6–8; `S` returns to 0 at edge 9; `R`=0 throughout; `BUSY` falls after GAP.
- **Fill to full:**
  - Stimulus: with `DEPTH`=4, push 5 commands back-to-back, each `HOLD`=7.
  - Required:
    - `CMD_READY` drops after the 5th push (4 buffered after the first pops).
    - The 6th command stalls until a pop.
    - The order of commands on `S`/`R` matches push order.
    - Consecutive drives are separated by exactly one S=R=0 cycle.
- **Reset/set alternation:**
  - Stimulus: push 01,10,01,10, each `HOLD`=0.
  - Required: 1-cycle pulses R,S,R,S with period 2; the assertion `S & R` never fires.
- **Toggle with the macro defined:**
  - Stimulus: `Q_FB`=1, push 11 with `HOLD`=1.
  - Required: `R`=1 for 2 cycles. Repeated with `Q_FB`=0, `S`=1 for 2 cycles; `ERR`=0.
- **Toggle without the macro:**
  - Stimulus: push 11 with `HOLD`=3.
  - Required: `S`=`R`=0 for 4 cycles; `ERR`=1 from the pop edge and held until `RSTn`=0.
- **Mid-drive reset:**
  - Stimulus: 3 commands queued, assert `RSTn`=0 for one cycle during DRIVE.
  - Required: at the next edge `S`=`R`=0, `BUSY`=0 and `CMD_READY`=1; no queued command executes afterwards.
